// File: rtl/matrix_bus_pkg.sv
// Shared types and constants for the matrix processor bus master.
package matrix_bus_pkg;

    localparam int unsigned WORD_W         = 16;
    localparam int unsigned STROBE_CNT_W   = 4;
    localparam int unsigned POLL_CNT_W     = 16;
    localparam int unsigned WR_RDY_BIT_DEF = 0;
    localparam int unsigned RD_RDY_BIT_DEF = 1;

    localparam logic DATA_SEL   = 1'b1;
    localparam logic STATUS_SEL = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STAT,
        ST_EVAL,
        ST_DATA,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic              write;
        logic [WORD_W-1:0] data;
    } cmd_t;

endpackage

// File: rtl/matrix_bus_strobe_timer.sv
// Loadable down-counter; terminal_c_o marks the last cycle of a timed access phase.
module matrix_bus_strobe_timer
    import matrix_bus_pkg::*;
#(
    parameter int unsigned CNT_W = STROBE_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             terminal_c_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign terminal_c_o = (cnt_q == '0);

endmodule

// File: rtl/matrix_bus_master.sv
// Host-command to matrix-processor bus master: polls status, then does one data access.
// Optional poll timeout with sticky err is enabled by defining MATRIX_BUS_TIMEOUT_EN.
module matrix_bus_master
    import matrix_bus_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned POLL_LIMIT    = 255,
    parameter int unsigned WR_RDY_BIT    = WR_RDY_BIT_DEF,
    parameter int unsigned RD_RDY_BIT    = RD_RDY_BIT_DEF
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [WORD_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_data,
    output logic              busy,
    output logic              err,
    output logic [WORD_W-1:0] bus_din,
    input  logic [WORD_W-1:0] bus_dout,
    output logic              cs,
    output logic              rd,
    output logic              wr,
    output logic              dataORstatus
);

    if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15) begin : g_bad_strobe
        $error("STROBE_CYCLES must be in 1..15");
    end
    if (POLL_LIMIT < 1 || POLL_LIMIT > 65535) begin : g_bad_poll
        $error("POLL_LIMIT must be in 1..65535");
    end
    if (WR_RDY_BIT >= WORD_W || RD_RDY_BIT >= WORD_W) begin : g_bad_bit
        $error("status bit index out of range");
    end

    state_e            state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic              rdy_q, rdy_d;
    logic [WORD_W-1:0] rsp_data_q, rsp_data_d;
    logic [WORD_W-1:0] bus_din_q, bus_din_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              cs_q, cs_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              dos_q, dos_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              busy_q, busy_d;

    logic              accept_c;
    logic              load_c;
    logic              terminal_c;
    logic              timeout_c;

    matrix_bus_strobe_timer #(
        .CNT_W (STROBE_CNT_W)
    ) u_strobe_timer (
        .clk_i        (sysclk),
        .rst_ni       (reset),
        .load_i       (load_c),
        .load_val_i   (STROBE_CNT_W'(STROBE_CYCLES - 1)),
        .terminal_c_o (terminal_c)
    );

    // Next state plus the next value of every registered output, decoded from state_d
    // so that strobes line up exactly with the phase they belong to.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        rdy_d      = rdy_q;
        rsp_data_d = rsp_data_q;
        accept_c   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    accept_c   = 1'b1;
                    cmd_d.write = cmd_write;
                    cmd_d.data  = cmd_data;
                    state_d    = ST_STAT;
                end
            end
            ST_STAT: begin
                if (terminal_c) begin
                    rdy_d   = cmd_q.write ? bus_dout[WR_RDY_BIT] : bus_dout[RD_RDY_BIT];
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (rdy_q) begin
                    state_d = ST_DATA;
                end else if (timeout_c) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STAT;
                end
            end
            ST_DATA: begin
                if (terminal_c) begin
                    if (!cmd_q.write) begin
                        rsp_data_d = bus_dout;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        load_c      = (state_d != state_q) && (state_d == ST_STAT || state_d == ST_DATA);
        cs_d        = (state_d == ST_STAT) || (state_d == ST_DATA);
        rd_d        = (state_d == ST_STAT) || (state_d == ST_DATA && !cmd_d.write);
        wr_d        = (state_d == ST_DATA) && cmd_d.write;
        dos_d       = (state_d == ST_DATA) ? DATA_SEL : STATUS_SEL;
        bus_din_d   = (state_d == ST_DATA || state_d == ST_DONE) ? cmd_d.data : '0;
        rsp_valid_d = (state_d == ST_DONE) && !cmd_d.write;
        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = !cmd_ready_d;
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            rdy_q       <= 1'b0;
            rsp_data_q  <= '0;
            bus_din_q   <= '0;
            rsp_valid_q <= 1'b0;
            cs_q        <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            dos_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            rdy_q       <= rdy_d;
            rsp_data_q  <= rsp_data_d;
            bus_din_q   <= bus_din_d;
            rsp_valid_q <= rsp_valid_d;
            cs_q        <= cs_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            dos_q       <= dos_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
        end
    end

`ifdef MATRIX_BUS_TIMEOUT_EN
    logic [POLL_CNT_W-1:0] poll_q, poll_d;
    logic                  err_q, err_d;
    logic                  poll_fail_c;

    // poll_q counts failed polls already taken; the POLL_LIMIT-th failure aborts.
    assign poll_fail_c = (state_q == ST_EVAL) && !rdy_q;
    assign timeout_c   = (poll_q == POLL_CNT_W'(POLL_LIMIT - 1));

    always_comb begin
        poll_d = poll_q;
        err_d  = err_q;
        if (accept_c) begin
            poll_d = '0;
            err_d  = 1'b0;
        end else if (poll_fail_c) begin
            if (timeout_c) begin
                err_d = 1'b1;
            end else begin
                poll_d = poll_q + POLL_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            poll_q <= '0;
            err_q  <= 1'b0;
        end else begin
            poll_q <= poll_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_accept;

    assign unused_accept = accept_c;
    assign timeout_c     = 1'b0;
    assign err           = 1'b0;
`endif

    assign cmd_ready    = cmd_ready_q;
    assign busy         = busy_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign bus_din      = bus_din_q;
    assign cs           = cs_q;
    assign rd           = rd_q;
    assign wr           = wr_q;
    assign dataORstatus = dos_q;

endmodule

// File: tb/tb_matrix_bus_master.sv
// Self-checking bench for matrix_bus_master with a behavioural processor-bus model.
module tb_matrix_bus_master;

    localparam int unsigned SC = 2;
    localparam int unsigned PL = 4;

    logic        sysclk = 1'b0;
    logic        reset  = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [15:0] cmd_data  = 16'h0000;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        busy;
    logic        err;
    logic [15:0] bus_din;
    logic [15:0] bus_dout;
    logic        cs, rd, wr, dataORstatus;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int          polls       = 0;
    int          fail_polls  = 0;
    logic [15:0] rd_word     = 16'h0000;
    logic [15:0] rdy_status  = 16'h0000;
    int          stat_phases = 0;
    int          wr_phases   = 0;
    int          rsp_pulses  = 0;
    logic        prev_stat   = 1'b0;
    logic        prev_wr     = 1'b0;

    logic [15:0] exp_rsp[$];
    logic [15:0] exp_wr[$];

    matrix_bus_master #(
        .STROBE_CYCLES (SC),
        .POLL_LIMIT    (PL),
        .WR_RDY_BIT    (0),
        .RD_RDY_BIT    (1)
    ) dut (
        .sysclk       (sysclk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_data     (cmd_data),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .busy         (busy),
        .err          (err),
        .bus_din      (bus_din),
        .bus_dout     (bus_dout),
        .cs           (cs),
        .rd           (rd),
        .wr           (wr),
        .dataORstatus (dataORstatus)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    // Processor model: status is ready only after fail_polls failed status phases.
    always_comb begin
        if (dataORstatus)            bus_dout = rd_word;
        else if (polls > fail_polls) bus_dout = rdy_status;
        else                         bus_dout = 16'h0000;
    end

    // Bus monitor and scoreboard.
    always @(negedge sysclk) begin
        if (!reset) begin
            prev_stat = 1'b0;
            prev_wr   = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) polls = 0;
            if (cs && rd && !dataORstatus && !prev_stat) begin
                polls++;
                stat_phases++;
            end
            if (wr && !prev_wr) begin
                wr_phases++;
                total++;
                if (exp_wr.size() == 0) begin
                    bad++;
                    $display("FAIL wr_unexpected: bus_din=%h with no write pending", bus_din);
                end else begin
                    logic [15:0] e;
                    e = exp_wr.pop_front();
                    if (bus_din !== e) begin
                        bad++;
                        $display("FAIL wr_data: got %h want %h", bus_din, e);
                    end
                end
            end
            prev_stat = cs && rd && !dataORstatus;
            prev_wr   = wr;

            total++;
            if ((rd && wr) || ((rd || wr) && !cs) || (busy !== !cmd_ready)) begin
                bad++;
                $display("FAIL invariant: cs=%b rd=%b wr=%b busy=%b cmd_ready=%b", cs, rd, wr, busy, cmd_ready);
            end

            if (rsp_valid) begin
                rsp_pulses++;
                total++;
                if (exp_rsp.size() == 0) begin
                    bad++;
                    $display("FAIL rsp_unexpected: rsp_data=%h", rsp_data);
                end else begin
                    logic [15:0] e;
                    e = exp_rsp.pop_front();
                    if (rsp_data !== e) begin
                        bad++;
                        $display("FAIL rsp_data: got %h want %h", rsp_data, e);
                    end
                end
            end
        end
    end

    task automatic issue(input logic w, input logic [15:0] d, input logic [15:0] rword,
                         input logic [15:0] rstat, input int fails, output int acc);
        @(posedge sysclk); #1;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_data  = d;
        acc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge sysclk);
            if (cmd_ready) begin
                acc = cyc;
                break;
            end
        end
        total++;
        if (acc < 0) begin
            bad++;
            $display("FAIL accept_timeout: cmd_ready=%b want 1", cmd_ready);
        end
        @(posedge sysclk); #1;
        cmd_valid  = 1'b0;
        cmd_data   = 16'h0000;
        rd_word    = rword;
        rdy_status = rstat;
        fail_polls = fails;
        if (w) exp_wr.push_back(d);
        else   exp_rsp.push_back(rword);
    endtask

    task automatic wait_idle(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge sysclk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #12;
        total++;
        if ({cs, rd, wr, dataORstatus, rsp_valid, busy, err, cmd_ready} !== 8'b0000_0001) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 00000001",
                     {cs, rd, wr, dataORstatus, rsp_valid, busy, err, cmd_ready});
        end
        total++;
        if ({bus_din, rsp_data} !== 32'h0) begin
            bad++;
            $display("FAIL reset_data: bus_din=%h rsp_data=%h want 0", bus_din, rsp_data);
        end
        @(negedge sysclk);
        reset = 1'b1;
    endtask

    task automatic test_write;
        int acc, rel;
        logic [5:0]  e;
        logic [15:0] e_din;
        issue(1'b1, 16'h3C00, 16'h0000, 16'h0001, 0, acc);
        for (int k = 0; k < 7; k++) begin
            @(negedge sysclk);
            rel = cyc - acc;
            e[5] = (rel == 1 || rel == 2 || rel == 4 || rel == 5);
            e[4] = (rel == 1 || rel == 2);
            e[3] = (rel == 4 || rel == 5);
            e[2] = (rel == 4 || rel == 5);
            e[1] = (rel == 7);
            e[0] = 1'b0;
            e_din = (rel >= 4 && rel <= 6) ? 16'h3C00 : 16'h0000;
            total++;
            if ({cs, rd, wr, dataORstatus, cmd_ready, rsp_valid} !== e) begin
                bad++;
                $display("FAIL write_strobes cyc%0d: got %b want %b", rel,
                         {cs, rd, wr, dataORstatus, cmd_ready, rsp_valid}, e);
            end
            total++;
            if (bus_din !== e_din) begin
                bad++;
                $display("FAIL write_bus_din cyc%0d: got %h want %h", rel, bus_din, e_din);
            end
        end
    endtask

    task automatic test_read;
        int acc, rel;
        logic [5:0]  e;
        logic [15:0] e_din;
        issue(1'b0, 16'h1111, 16'hA5A5, 16'h0002, 0, acc);
        for (int k = 0; k < 7; k++) begin
            @(negedge sysclk);
            rel = cyc - acc;
            e[5] = (rel == 1 || rel == 2 || rel == 4 || rel == 5);
            e[4] = e[5];
            e[3] = 1'b0;
            e[2] = (rel == 4 || rel == 5);
            e[1] = (rel == 7);
            e[0] = (rel == 6);
            e_din = (rel >= 4 && rel <= 6) ? 16'h1111 : 16'h0000;
            total++;
            if ({cs, rd, wr, dataORstatus, cmd_ready, rsp_valid} !== e) begin
                bad++;
                $display("FAIL read_strobes cyc%0d: got %b want %b", rel,
                         {cs, rd, wr, dataORstatus, cmd_ready, rsp_valid}, e);
            end
            total++;
            if (bus_din !== e_din) begin
                bad++;
                $display("FAIL read_bus_din cyc%0d: got %h want %h", rel, bus_din, e_din);
            end
        end
        total++;
        if (rsp_data !== 16'hA5A5) begin
            bad++;
            $display("FAIL read_rsp_hold: got %h want a5a5", rsp_data);
        end
    endtask

    task automatic test_poll_retry;
        int acc, s0, w0;
        bit ok;
        s0 = stat_phases;
        w0 = wr_phases;
        issue(1'b1, 16'h5A5A, 16'h0000, 16'h0001, 3, acc);
        wait_idle(100, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL poll_done: cmd_ready=%b want 1", cmd_ready); end
        total++;
        if (stat_phases - s0 != 4) begin
            bad++; $display("FAIL poll_stat_phases: got %0d want 4", stat_phases - s0);
        end
        total++;
        if (wr_phases - w0 != 1) begin
            bad++; $display("FAIL poll_wr_phases: got %0d want 1", wr_phases - w0);
        end
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL poll_err: got %b want 0", err); end
    endtask

`ifdef MATRIX_BUS_TIMEOUT_EN
    task automatic test_timeout;
        int acc, s0, w0, r0;
        bit ok;
        s0 = stat_phases;
        w0 = wr_phases;
        r0 = rsp_pulses;
        issue(1'b1, 16'h0BAD, 16'h0000, 16'h0001, 1000, acc);
        wait_idle(100, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL to_idle: cmd_ready=%b want 1", cmd_ready); end
        total++;
        if (stat_phases - s0 != int'(PL)) begin
            bad++; $display("FAIL to_stat_phases: got %0d want %0d", stat_phases - s0, PL);
        end
        total++;
        if (wr_phases != w0 || rsp_pulses != r0) begin
            bad++; $display("FAIL to_no_access: wr=%0d rsp=%0d want 0 0", wr_phases - w0, rsp_pulses - r0);
        end
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL to_err_set: got %b want 1", err); end
        exp_wr.delete();
        issue(1'b0, 16'h0000, 16'h7E7E, 16'h0002, 0, acc);
        @(negedge sysclk);
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL to_err_clear: got %b want 0", err); end
        wait_idle(100, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL to_next_done: cmd_ready=%b want 1", cmd_ready); end
    endtask
`else
    task automatic test_timeout;
        int acc, s0, w0;
        bit ok;
        s0 = stat_phases;
        w0 = wr_phases;
        issue(1'b1, 16'h0BAD, 16'h0000, 16'h0001, 6, acc);
        wait_idle(200, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL nto_done: cmd_ready=%b want 1", cmd_ready); end
        total++;
        if (stat_phases - s0 != 7) begin
            bad++; $display("FAIL nto_stat_phases: got %0d want 7", stat_phases - s0);
        end
        total++;
        if (wr_phases - w0 != 1) begin
            bad++; $display("FAIL nto_wr_phases: got %0d want 1", wr_phases - w0);
        end
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL nto_err: got %b want 0", err); end
    endtask
`endif

    task automatic test_reset_mid;
        int acc, r0;
        bit hit;
        r0 = rsp_pulses;
        issue(1'b0, 16'h0000, 16'h5555, 16'h0002, 0, acc);
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sysclk);
            if (rd && dataORstatus) begin
                hit = 1'b1;
                break;
            end
        end
        total++;
        if (!hit) begin bad++; $display("FAIL rm_reach_data: rd=%b dos=%b want 1 1", rd, dataORstatus); end
        #1 reset = 1'b0;
        #1;
        total++;
        if ({cs, rd, wr, dataORstatus, rsp_valid, busy} !== 6'b0) begin
            bad++;
            $display("FAIL rm_strobes_drop: got %b want 000000", {cs, rd, wr, dataORstatus, rsp_valid, busy});
        end
        exp_rsp.delete();
        @(negedge sysclk);
        @(negedge sysclk);
        #1 reset = 1'b1;
        for (int i = 0; i < 4; i++) @(negedge sysclk);
        total++;
        if (cmd_ready !== 1'b1 || rsp_pulses != r0) begin
            bad++;
            $display("FAIL rm_after: cmd_ready=%b rsp_pulses=%0d want 1 %0d", cmd_ready, rsp_pulses, r0);
        end
        total++;
        if (rsp_data !== 16'h0000) begin
            bad++; $display("FAIL rm_rsp_data: got %h want 0000", rsp_data);
        end
    endtask

    task automatic test_back_to_back;
        int acc;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            issue((i % 2) == 0, 16'(16'h1001 * (i + 1)), 16'(16'hB000 + i), 16'h0003, i % 2, acc);
        end
        wait_idle(100, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL b2b_done: cmd_ready=%b want 1", cmd_ready); end
        total++;
        if (exp_wr.size() != 0 || exp_rsp.size() != 0) begin
            bad++;
            $display("FAIL b2b_pending: wr=%0d rsp=%0d want 0 0", exp_wr.size(), exp_rsp.size());
        end
        issue(1'b1, 16'hCAFE, 16'h0BAD, 16'h0003, 0, acc);
        wait_idle(100, ok);
        total++;
        if (rsp_data !== 16'hB003) begin
            bad++; $display("FAIL b2b_rsp_hold: got %h want b003", rsp_data);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_poll_retry();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(negedge sysclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
